// File: rtl/shift_sub_divider_if.sv
// Handshake and operand/result bundle for shift_sub_divider.
// With DIVIDER_DZ_FLAG_EN defined, the bundle also carries the dz_o divide-by-zero flag.
interface shift_sub_divider_if #(
  parameter int N = 4
);
  logic           st;
  logic [2*N-1:0] dividend_i;
  logic [N-1:0]   divisor_i;
  logic [N-1:0]   quotient_o;
  logic [N-1:0]   remainder_o;
  logic           ovf_o;
  logic           busy;
  logic           done;
`ifdef DIVIDER_DZ_FLAG_EN
  logic           dz_o;
`endif

  modport master (
`ifdef DIVIDER_DZ_FLAG_EN
    input  dz_o,
`endif
    output st, dividend_i, divisor_i,
    input  quotient_o, remainder_o, ovf_o, busy, done
  );

  modport slave (
`ifdef DIVIDER_DZ_FLAG_EN
    output dz_o,
`endif
    input  st, dividend_i, divisor_i,
    output quotient_o, remainder_o, ovf_o, busy, done
  );
endinterface

// File: rtl/shift_sub_divider.sv
// Restoring shift-and-subtract divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Optional macro DIVIDER_DZ_FLAG_EN adds the dz_o divide-by-zero flag.
module shift_sub_divider #(
  parameter int N = 4
) (
  input logic               clk,
  input logic               rst,
  shift_sub_divider_if.slave bus
);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_CHK,
    S_ITER,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_next;

  logic [2*N:0]   r_acc;
  logic [N-1:0]   r_dsr;
  logic [CNT_W-1:0] r_cnt;
  logic           r_ovf;
  logic [N-1:0]   r_quotient;
  logic [N-1:0]   r_remainder;
  logic           r_ovf_o;
`ifdef DIVIDER_DZ_FLAG_EN
  logic           r_dz;
  logic           r_dz_o;
`endif

  logic [2*N:0]   w_shift;
  logic [N:0]     w_diff;
  logic           w_ge;
  logic           w_ovf_chk;
  logic           w_last_iter;

  // Upper half >= divisor means the quotient cannot fit in N bits; a zero divisor always trips it.
  assign w_ovf_chk   = r_acc[2*N:N] >= {1'b0, r_dsr};
  assign w_shift     = {r_acc[2*N-1:0], 1'b0};
  assign w_ge        = w_shift[2*N:N] >= {1'b0, r_dsr};
  assign w_diff      = w_shift[2*N:N] - {1'b0, r_dsr};
  assign w_last_iter = (r_cnt == CNT_W'(N - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next   = r_state;
    bus.busy = 1'b1;
    bus.done = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (bus.st) w_next = S_LOAD_CHK;
      end
      S_LOAD_CHK: w_next = w_ovf_chk ? S_DONE : S_ITER;
      S_ITER:     if (w_last_iter) w_next = S_DONE;
      S_DONE: begin
        bus.done = 1'b1;
        w_next   = S_IDLE;
      end
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_dsr       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_ovf_o     <= 1'b0;
`ifdef DIVIDER_DZ_FLAG_EN
      r_dz        <= 1'b0;
      r_dz_o      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.st) begin
            r_acc <= {1'b0, bus.dividend_i};
            r_dsr <= bus.divisor_i;
            r_ovf <= 1'b0;
`ifdef DIVIDER_DZ_FLAG_EN
            r_dz  <= 1'b0;
`endif
          end
        end
        S_LOAD_CHK: begin
          if (w_ovf_chk) begin
            r_ovf <= 1'b1;
`ifdef DIVIDER_DZ_FLAG_EN
            r_dz  <= (r_dsr == '0);
`endif
          end else begin
            r_cnt <= '0;
          end
        end
        S_ITER: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // Restoring step: keep the difference only when it does not go negative.
          if (w_ge) r_acc <= {w_diff, w_shift[N-1:1], 1'b1};
          else      r_acc <= w_shift;
        end
        S_DONE: begin
          r_quotient  <= r_ovf ? '0 : r_acc[N-1:0];
          r_remainder <= r_ovf ? '0 : r_acc[2*N-1:N];
          r_ovf_o     <= r_ovf;
`ifdef DIVIDER_DZ_FLAG_EN
          r_dz_o      <= r_dz;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient_o  = r_quotient;
  assign bus.remainder_o = r_remainder;
  assign bus.ovf_o       = r_ovf_o;
`ifdef DIVIDER_DZ_FLAG_EN
  assign bus.dz_o        = r_dz_o;
`endif
endmodule

// File: tb/tb_shift_sub_divider.sv
// Scoreboard bench for shift_sub_divider: directed cases plus random operands against an arithmetic model.
// Define DIVIDER_DZ_FLAG_EN to also check dz_o.
module tb_shift_sub_divider;
  localparam int N = 4;

  typedef struct {
    int start_cyc;
    int lat;
    bit chk_lat;
    int q;
    int r;
    bit ovf;
    bit dz;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errs = 0;
  int   n_done = 0;
  exp_t exp_q[$];

  shift_sub_divider_if #(.N(N)) bus ();
  shift_sub_divider #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Quotient must fit in N bits; a zero divisor never fits.
  function automatic exp_t model(input int dvd, input int dsr);
    exp_t e;
    e.start_cyc = 0;
    e.chk_lat   = 1'b0;
    e.dz        = (dsr == 0);
    if (dsr == 0 || (dvd / dsr) > (1 << N) - 1) begin
      e.ovf = 1'b1; e.q = 0; e.r = 0; e.lat = 1;
    end else begin
      e.ovf = 1'b0; e.q = dvd / dsr; e.r = dvd % dsr; e.lat = N + 1;
    end
    return e;
  endfunction

  // Monitor: done marks DONE; results appear after the edge that leaves it.
  always begin
    exp_t e;
    @(negedge clk);
    if (bus.done === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        if (e.chk_lat) check("latency", cyc - e.start_cyc, e.lat);
        @(negedge clk);
        check("quotient", bus.quotient_o, e.q);
        check("remainder", bus.remainder_o, e.r);
        check("ovf", bus.ovf_o, e.ovf);
`ifdef DIVIDER_DZ_FLAG_EN
        check("dz", bus.dz_o, e.dz);
`endif
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (bus.busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (bus.busy) check("wait_idle_timeout", 1, 0);
  endtask

  task automatic wait_done();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.done && k < 100);
    if (!bus.done) check("wait_done_timeout", 1, 0);
  endtask

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic start_op(input int dvd, input int dsr, input bit push, input bit chk_lat);
    exp_t e;
    wait_idle();
    bus.st         = 1'b1;
    bus.dividend_i = dvd[2*N-1:0];
    bus.divisor_i  = dsr[N-1:0];
    @(negedge clk);
    bus.st = 1'b0;
    if (push) begin
      e = model(dvd, dsr);
      e.start_cyc = cyc;
      e.chk_lat   = chk_lat;
      exp_q.push_back(e);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   first_done;
    int   done_before;
    int   dvd;
    int   dsr;
    int   k;

    rst = 1'b1;
    bus.st = 1'b0;
    bus.dividend_i = '0;
    bus.divisor_i  = '0;
    #1;
    check("rst_quotient", bus.quotient_o, 0);
    check("rst_remainder", bus.remainder_o, 0);
    check("rst_ovf", bus.ovf_o, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
`ifdef DIVIDER_DZ_FLAG_EN
    check("rst_dz", bus.dz_o, 0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic, operands disturbed mid-iteration, overflow, divide by zero.
    start_op(135, 13, 1'b1, 1'b1);
    start_op(100, 7, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    bus.dividend_i = 8'd255;
    bus.divisor_i  = 4'd1;
    start_op(200, 5, 1'b1, 1'b1);
    start_op(50, 0, 1'b1, 1'b1);

    // Back-to-back with st held high.
    wait_idle();
    @(negedge clk);
    bus.st         = 1'b1;
    bus.dividend_i = 8'd135;
    bus.divisor_i  = 4'd13;
    @(negedge clk);
    e = model(135, 13);
    e.start_cyc = cyc;
    e.chk_lat   = 1'b1;
    exp_q.push_back(e);
    exp_q.push_back(model(15, 15));
    @(negedge clk);
    bus.dividend_i = 8'd15;
    bus.divisor_i  = 4'd15;
    wait_done();
    first_done = cyc;
    repeat (4) @(negedge clk);
    check("hold_quotient", bus.quotient_o, 10);
    check("hold_remainder", bus.remainder_o, 5);
    check("hold_ovf", bus.ovf_o, 0);
    wait_done();
    check("b2b_spacing", cyc - first_done, N + 3);
    bus.st = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Abort in the third ITER cycle.
    start_op(135, 13, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    done_before = n_done;
    rst = 1'b1;
    #1;
    check("abort_quotient", bus.quotient_o, 0);
    check("abort_remainder", bus.remainder_o, 0);
    check("abort_ovf", bus.ovf_o, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_no_done", n_done, done_before);
    start_op(99, 10, 1'b1, 1'b1);

    // Random operands, biased toward non-overflowing pairs.
    for (int i = 0; i < 60; i++) begin
      dsr = int'($urandom_range(0, (1 << N) - 1));
      if ($urandom_range(0, 3) != 0 && dsr != 0)
        dvd = int'($urandom_range(0, dsr * (1 << N) - 1));
      else
        dvd = int'($urandom_range(0, (1 << (2 * N)) - 1));
      start_op(dvd, dsr, 1'b1, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
